// File: rtl/bus_slave.sv
// Serial bus slave: decodes a device ID from a 16-bit serial address, then
// stores a written byte or returns a stored byte serially on B_BUS_IN.
`timescale 1ns/1ps
module bus_slave #(
   parameter int unsigned            DEV_BITS   = 4,
   parameter logic [DEV_BITS-1:0]    SLAVE_ID   = 4'h1,
   parameter int unsigned            MEM_ADDR_W = 12
) (
   input  logic CLK,
   input  logic RST,
   input  logic B_UTIL,
   input  logic B_RW,
   input  logic B_BUS_OUT,
   output logic B_ACK,
   output logic B_BUS_IN,
   output logic S_BSY
);

   localparam int unsigned ADDR_W    = DEV_BITS + MEM_ADDR_W;
   localparam int unsigned SH_W      = ADDR_W - 1;
   localparam int unsigned CNT_W     = $clog2(ADDR_W);
   localparam int unsigned MEM_DEPTH = 1 << MEM_ADDR_W;

   typedef enum logic [2:0] {
      IDLE, ADDR, ACK, WDATA, WACK, RDATA, WAIT_REL
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [SH_W-1:0]    addr_q, addr_d;
   logic               rw_q, rw_d;
   logic [7:0]         sh_q, sh_d;
   logic               ack_q, ack_d;
   logic               bin_q, bin_d;
   logic               bsy_q, bsy_d;

   logic [ADDR_W-1:0]  addr_full_c;
   logic [7:0]         mem_rdata_c;
   logic               mem_we_c;
   logic [7:0]         mem [MEM_DEPTH];

   // Full address including the bit being sampled this cycle.
   assign addr_full_c = {addr_q, B_BUS_OUT};
   assign mem_rdata_c = mem[addr_full_c[MEM_ADDR_W-1:0]];

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      rw_d     = rw_q;
      sh_d     = sh_q;
      ack_d    = 1'b0;
      bin_d    = 1'b0;
      mem_we_c = 1'b0;
      case (state_q)
         IDLE: begin
            if (B_UTIL) begin
               addr_d  = SH_W'(B_BUS_OUT);
               rw_d    = B_RW;
               cnt_d   = CNT_W'(1);
               state_d = ADDR;
            end
         end
         ADDR: begin
            if (!B_UTIL) begin
               state_d = IDLE;
            end else begin
               addr_d = addr_full_c[SH_W-1:0];
               cnt_d  = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(ADDR_W - 1)) begin
                  cnt_d = '0;
                  if (addr_full_c[ADDR_W-1 -: DEV_BITS] == SLAVE_ID) begin
                     state_d = ACK;
                     ack_d   = 1'b1;
                     if (!rw_q) sh_d = mem_rdata_c;
                  end else begin
                     state_d = WAIT_REL;
                  end
               end
            end
         end
         ACK: begin
            if (!B_UTIL) begin
               state_d = IDLE;
            end else if (cnt_q == '0) begin
               ack_d = 1'b1;
               cnt_d = CNT_W'(1);
            end else begin
               cnt_d = '0;
               if (rw_q) begin
                  state_d = WDATA;
               end else begin
                  // First read bit leaves on the cycle right after ACK.
                  state_d = RDATA;
                  bin_d   = sh_q[7];
                  sh_d    = {sh_q[6:0], 1'b0};
               end
            end
         end
         WDATA: begin
            if (!B_UTIL) begin
               state_d = IDLE;
            end else begin
               sh_d  = {sh_q[6:0], B_BUS_OUT};
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(7)) begin
                  mem_we_c = 1'b1;
                  cnt_d    = '0;
                  ack_d    = 1'b1;
                  state_d  = WACK;
               end
            end
         end
         WACK: begin
            state_d = B_UTIL ? WAIT_REL : IDLE;
         end
         RDATA: begin
            if (!B_UTIL) begin
               state_d = IDLE;
            end else if (cnt_q == CNT_W'(7)) begin
               cnt_d   = '0;
               state_d = WAIT_REL;
            end else begin
               bin_d = sh_q[7];
               sh_d  = {sh_q[6:0], 1'b0};
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         WAIT_REL: begin
            if (!B_UTIL) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (state_d == IDLE) cnt_d = '0;
      bsy_d = (state_d != IDLE);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         rw_q    <= 1'b0;
         sh_q    <= '0;
         ack_q   <= 1'b0;
         bin_q   <= 1'b0;
         bsy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         rw_q    <= rw_d;
         sh_q    <= sh_d;
         ack_q   <= ack_d;
         bin_q   <= bin_d;
         bsy_q   <= bsy_d;
      end
   end

   // Byte store; contents survive reset, but a reset edge suppresses the write.
   always_ff @(posedge CLK) begin
      if (mem_we_c && !RST) mem[addr_q[MEM_ADDR_W-1:0]] <= {sh_q[6:0], B_BUS_OUT};
   end

   assign B_ACK    = ack_q;
   assign B_BUS_IN = bin_q;
   assign S_BSY    = bsy_q;

endmodule

// File: tb/tb_bus_slave.sv
// Bench for bus_slave: table of bus transactions expanded into per-cycle
// expected outputs that a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_bus_slave;

   logic CLK = 1'b0;
   logic RST, B_UTIL, B_RW, B_BUS_OUT;
   logic B_ACK, B_BUS_IN, S_BSY;

   int checks = 0;
   int errors = 0;

   bus_slave #(.DEV_BITS(4), .SLAVE_ID(4'h1), .MEM_ADDR_W(12)) dut (
      .CLK(CLK), .RST(RST), .B_UTIL(B_UTIL), .B_RW(B_RW), .B_BUS_OUT(B_BUS_OUT),
      .B_ACK(B_ACK), .B_BUS_IN(B_BUS_IN), .S_BSY(S_BSY)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic ack;
      logic bin;
      logic bsy;
      int   tag;
      int   cyc;
   } exp_t;

   exp_t sb[$];

   // Transaction record: n = number of cycles B_UTIL is held high,
   // rst = RST asserted on the last of those cycles, flip = B_RW inverted after cycle 1.
   typedef struct {
      logic        rw;
      logic [15:0] addr;
      logic [7:0]  data;
      int          n;
      logic        rst;
      logic        flip;
      logic        exp_match;
      logic [7:0]  exp_rd;
   } txn_t;

   always @(negedge CLK) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         checks += 3;
         if (B_ACK !== e.ack) begin
            errors++;
            $display("FAIL ack txn %0d cyc %0d: got %b want %b", e.tag, e.cyc, B_ACK, e.ack);
         end
         if (B_BUS_IN !== e.bin) begin
            errors++;
            $display("FAIL bus_in txn %0d cyc %0d: got %b want %b", e.tag, e.cyc, B_BUS_IN, e.bin);
         end
         if (S_BSY !== e.bsy) begin
            errors++;
            $display("FAIL bsy txn %0d cyc %0d: got %b want %b", e.tag, e.cyc, S_BSY, e.bsy);
         end
      end
   end

   task automatic step(input logic rst, input logic util, input logic rw, input logic bo,
                       input exp_t e);
      RST = rst; B_UTIL = util; B_RW = rw; B_BUS_OUT = bo;
      @(posedge CLK);
      sb.push_back(e);
      @(negedge CLK);
   endtask

   task automatic run_txn(input int tag, input txn_t t);
      exp_t e;
      logic bo, rw, rst, wr_done;
      int o;
      wr_done = t.exp_match && t.rw && (t.n > 26 || (t.n == 26 && !t.rst));
      for (int c = 1; c <= t.n; c++) begin
         o = c + 1;
         if (c <= 16)                bo = t.addr[16-c];
         else if (c >= 19 && c <= 26) bo = t.data[26-c];
         else                        bo = 1'($urandom_range(0, 1));
         rw  = (c == 1 || !t.flip) ? t.rw : ~t.rw;
         rst = t.rst && (c == t.n);
         e.tag = tag; e.cyc = o;
         if (rst) begin
            e.ack = 1'b0; e.bin = 1'b0; e.bsy = 1'b0;
         end else begin
            e.ack = t.exp_match && ((o == 17 || o == 18) || (o == 27 && wr_done));
            e.bin = (t.exp_match && !t.rw && o >= 19 && o <= 26) ? t.exp_rd[26-o] : 1'b0;
            e.bsy = 1'b1;
         end
         step(rst, 1'b1, rw, bo, e);
      end
      // Single release cycle: back-to-back transactions are allowed after it.
      e.tag = tag; e.cyc = t.n + 2; e.ack = 1'b0; e.bin = 1'b0; e.bsy = 1'b0;
      step(1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)), e);
   endtask

   txn_t tbl[13];

   initial begin
      exp_t z;
      // rw, addr, data, n, rst, flip, exp_match, exp_rd
      tbl[0]  = '{1'b1, 16'h1234, 8'hAD, 28, 1'b0, 1'b0, 1'b1, 8'h00}; // write
      tbl[1]  = '{1'b0, 16'h1234, 8'h00, 28, 1'b0, 1'b0, 1'b1, 8'hAD}; // read-back
      tbl[2]  = '{1'b1, 16'h2234, 8'h55, 28, 1'b0, 1'b0, 1'b0, 8'h00}; // ID mismatch
      tbl[3]  = '{1'b0, 16'h1234, 8'h00, 28, 1'b0, 1'b0, 1'b1, 8'hAD};
      tbl[4]  = '{1'b1, 16'h1234, 8'h3C, 22, 1'b0, 1'b0, 1'b1, 8'h00}; // abort after 4 bits
      tbl[5]  = '{1'b0, 16'h1234, 8'h00, 28, 1'b0, 1'b0, 1'b1, 8'hAD};
      tbl[6]  = '{1'b0, 16'h1234, 8'h00, 23, 1'b1, 1'b0, 1'b1, 8'hAD}; // reset at bit 3
      tbl[7]  = '{1'b0, 16'h1234, 8'h00, 28, 1'b0, 1'b0, 1'b1, 8'hAD};
      tbl[8]  = '{1'b1, 16'h1001, 8'hFF, 28, 1'b0, 1'b0, 1'b1, 8'h00};
      tbl[9]  = '{1'b0, 16'h1001, 8'h00, 28, 1'b0, 1'b0, 1'b1, 8'hFF}; // back-to-back read
      tbl[10] = '{1'b1, 16'h1234, 8'h77, 17, 1'b0, 1'b0, 1'b1, 8'h00}; // abort during ACK
      tbl[11] = '{1'b1, 16'h1FFF, 8'h81, 28, 1'b0, 1'b1, 1'b1, 8'h00}; // RW flips later
      tbl[12] = '{1'b0, 16'h1FFF, 8'h00, 28, 1'b0, 1'b1, 1'b1, 8'h81};

      RST = 1'b1; B_UTIL = 1'b0; B_RW = 1'b0; B_BUS_OUT = 1'b0;
      @(negedge CLK);
      z.ack = 1'b0; z.bin = 1'b0; z.bsy = 1'b0; z.tag = -1;
      // Reset state, then an idle cycle with the bus free.
      z.cyc = 0; step(1'b1, 1'b0, 1'b0, 1'b0, z);
      z.cyc = 1; step(1'b1, 1'b0, 1'b0, 1'b0, z);
      z.cyc = 2; step(1'b0, 1'b0, 1'b1, 1'b1, z);

      for (int i = 0; i < 13; i++) run_txn(i, tbl[i]);

      // Mid-address reset with B_UTIL held: bus busy is cleared next cycle.
      z.tag = 100;
      for (int c = 1; c <= 5; c++) begin
         z.cyc = c + 1; z.bsy = 1'b1;
         step(1'b0, 1'b1, 1'b0, 1'b1, z);
      end
      z.cyc = 7; z.bsy = 1'b0;
      step(1'b1, 1'b1, 1'b0, 1'b1, z);
      z.cyc = 8;
      step(1'b0, 1'b0, 1'b0, 1'b0, z);
      run_txn(101, tbl[1]);

      for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge CLK);
      if (sb.size() > 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, want 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bus_slave.md
Name: bus_slave

Overview:
- Serial bus slave on the downstream side of the bus master.
- Consumes the master's serial address/data stream (B_BUS_OUT, B_RW, B_UTIL) and decodes a device ID.
- Write: stores the byte into a local byte memory. Read: returns a stored byte serially on B_BUS_IN.
- Multiple instances share one bus and are distinguished by SLAVE_ID.

Parameters:
- DEV_BITS, 4, number of address MSBs used as device ID.
- SLAVE_ID, 4'h1, device ID this instance answers to.
- MEM_ADDR_W, 12, offset width; memory depth = 2**MEM_ADDR_W bytes (DEV_BITS + MEM_ADDR_W = 16).

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  synchronous reset, active-high.
- B_UTIL  in  1  master owns bus and is transacting.
- B_RW  in  1  1 = write, 0 = read; valid while B_UTIL=1.
- B_BUS_OUT  in  1  serial stream from master, MSB first.
- B_ACK  out  1  slave acknowledge.
- B_BUS_IN  out  1  serial read data to master, MSB first.
- S_BSY  out  1  high in any state other than IDLE.

Behaviour:
- Reset: B_ACK=0, B_BUS_IN=0, S_BSY=0, state IDLE, shift/bit counters 0.
  - Memory contents are not reset.
  - Reset asserted mid-transaction aborts it; outputs are 0 on the cycle after the reset edge; no memory write occurs.
- All outputs are registered. Idle value of B_BUS_IN is 0 (never z).
- States: IDLE, ADDR, ACK, WDATA, WACK, RDATA, WAIT_REL.
- IDLE:
  - On the first cycle with B_UTIL=1, sample B_BUS_OUT as address bit 15 and latch B_RW, then go to ADDR.
- ADDR:
  - Sample one bit per cycle for address bits 14..0 (16 bits total, counter 0..15).
  - After bit 0, compare addr[15 -: DEV_BITS] to SLAVE_ID.
  - Match: go to ACK. For reads, latch mem[addr[MEM_ADDR_W-1:0]] into the read shift register at this point.
  - Mismatch: go to WAIT_REL; B_ACK stays 0.
- ACK:
  - B_ACK=1 for exactly 2 cycles.
  - Then go to WDATA if the latched RW=1, otherwise RDATA.
- WDATA:
  - Sample 8 bits, MSB first, on the 8 cycles immediately after ACK.
  - On the edge that samples bit 0, write the byte to memory.
  - Go to WACK.
- WACK:
  - B_ACK=1 for 1 cycle, then go to WAIT_REL.
- RDATA:
  - B_BUS_IN carries bit 7 on the first cycle after ACK, down to bit 0 on the 8th cycle.
  - Then B_BUS_IN=0 and go to WAIT_REL.
- WAIT_REL:
  - Stay until B_UTIL=0, then go to IDLE.
  - A new transaction needs at least one B_UTIL=0 cycle.
- Abort:
  - B_UTIL=0 in any of ADDR, ACK, WDATA, WACK or RDATA returns the block to IDLE on the next edge.
  - No memory write occurs; B_ACK and B_BUS_IN are 0 from the next cycle.
  - A write is committed only if all 8 data bits were sampled.
- B_RW is latched once, during the first address bit; later changes are ignored.
- Address offset wraps naturally within MEM_ADDR_W; there is no out-of-range case.
- Timing: write completes at cycle 16 (address) + 2 (ACK) + 8 (data) + 1 (WACK) = 27 cycles from the first B_UTIL=1 cycle.

Test Plan:
- Write: B_UTIL=1, RW=1, address 0x1234 (ID 1, offset 0x234) sent MSB first, then data 8'hAD.
  -> B_ACK high on cycles 17-18 and again on cycle 27; mem[0x234]=8'hAD; S_BSY high from cycle 1 until B_UTIL drops.
- Read-back: after the write above, RW=0, address 0x1234.
  -> B_ACK high on cycles 17-18; B_BUS_IN = 1,0,1,0,1,1,0,1 on cycles 19-26; B_BUS_IN=0 afterwards.
- ID mismatch: write to address 0x2234 with data 8'h55.
  -> B_ACK never asserts; mem[0x234] still 8'hAD; block returns to IDLE after B_UTIL=0.
- Abort: write to 0x1234 with data 8'h3C; drop B_UTIL after 4 data bits.
  -> IDLE next cycle; mem[0x234] still 8'hAD; B_ACK=0.
- Reset mid-read: assert RST during RDATA bit 3.
  -> Next cycle B_BUS_IN=0, B_ACK=0, S_BSY=0; a subsequent read of 0x1234 returns 8'hAD.
- Back-to-back: write 0x1001=8'hFF, B_UTIL low 1 cycle, then read 0x1001.
  -> Read returns 8'hFF; the second transaction is accepted with only one idle cycle between them.
